fp_matmul_seq: RTL
==================

Name: fp_matmul_seq

Overview:
Sequenced, resource-shared counterpart to the combinational fixed-point matrix multiplier. It streams in matrix A (ROW_1 x COL_1) and then matrix B (COL_1 x COL_2), row-major, into internal register buffers. It computes C = A x B using one signed multiply-accumulate per cycle and streams C out row-major over a valid/ready interface. It sits between the attention-block data mover and downstream softmax/scale logic wherever area matters more than throughput.

Parameters:
DATA_WIDTH, 16, element width; signed two's complement fixed point.
FRAC_BITS, 8, fractional bits (Q8.8 by default).
ROW_1, 4, rows of A and of C.
COL_1, 4, columns of A = rows of B = dot-product length K.
COL_2, 4, columns of B and of C.
ACC_WIDTH, 40, accumulator width; must be >= 2*DATA_WIDTH + clog2(COL_1).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse; begins a job, honoured only in IDLE.
in_valid  in  1  input element valid.
in_ready  out  1  block can accept an input element.
in_data  in  DATA_WIDTH  A elements, then B elements, row-major.
out_valid  out  1  C element valid.
out_ready  in  1  downstream accepts the C element.
out_data  out  DATA_WIDTH  C element, row-major.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when the last C element handshakes.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; all counters and the accumulator = 0.
  - in_ready, out_valid, busy and done = 0; out_data = 0.
  - Buffer contents are don't-care.
- States and transitions:
  - IDLE -> LOAD_A on start.
  - LOAD_A -> LOAD_B after ROW_1*COL_1 input handshakes.
  - LOAD_B -> COMPUTE after COL_1*COL_2 input handshakes.
  - COMPUTE -> OUT after K cycles.
  - OUT -> COMPUTE when the output handshakes and the element was not the last.
  - OUT -> IDLE when the output handshakes on the last element.
- Input handshake:
  - in_ready = 1 exactly in LOAD_A and LOAD_B.
  - An element is written when in_valid & in_ready; the write index increments only on a handshake.
  - in_valid in any other state is ignored and nothing is stored.
- COMPUTE:
  - Counters i (row), j (column), k (0..K-1).
  - Each cycle: acc <= (k==0 ? 0 : acc) + sext(A[i][k]) * sext(B[k][j]), using a full-precision signed product.
  - After k = K-1 is accumulated, the block registers out_data = sat(acc >>> FRAC_BITS) and enters OUT.
- Result formatting:
  - The shift is arithmetic, so rounding is toward -infinity (truncation).
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. 0x8000..0x7FFF by default.
- OUT:
  - out_valid = 1, and out_data is held stable until out_ready.
  - On handshake: out_valid drops the next cycle. j increments; on wrap j = 0 and i increments.
- Latency:
  - First out_valid rises K+1 cycles after the final B handshake.
  - Each later element follows its predecessor's handshake by K+1 cycles (K compute cycles plus the OUT register).
- done: pulses for one cycle in the cycle after the last handshake, coincident with busy = 0.
- start:
  - Ignored when not IDLE.
  - start and done in the same cycle: start is accepted only once the state is IDLE, on the cycle after done.
- Backpressure: out_ready low for any duration stalls in OUT with no state change and no data corruption.
- Reset mid-job: the job is aborted immediately with all outputs at reset values. A new start after release runs a clean job; stale buffer data is fully overwritten by the load phases.
- Parameter corner: COL_1 = 1 must work (one COMPUTE cycle per element).

Test Plan:
1. Identity: A = I (0x0100 on diagonal), B elements = 0x0100..0x0F00 row-major -> C equals B in order; done pulses once; first out_valid arrives 5 cycles after the last B handshake.
2. Signed/truncation: A = all 0xFF80 (-0.5), B = all 0x0180 (1.5) -> every C element = 0xFD00 (-3.0). Additionally, A[0][0] = 0x0001 with B[0][0] = 0x0001 and all other elements 0 -> C[0][0] = 0x0000.
3. Saturation: A = B = all 0x7F00 -> all C = 0x7FFF. A = all 0x7F00 with B = all 0x8100 -> all C = 0x8000.
4. Backpressure and input gaps: random in_valid (50%) and out_ready (30%) -> C matches the golden model bit-exactly; out_data is stable whenever out_valid is high and out_ready is low.
5. start while busy: pulse start during LOAD_B and during OUT -> no effect; the job completes normally with exactly 16 outputs.
6. Reset mid-COMPUTE: assert rst_n low during the third C element -> outputs go to reset values in the same cycle. A subsequent full job with new data produces a correct C with no stale values.

Source files
------------

// File: rtl/fp_matmul_seq_if.sv
// Streaming bus for fp_matmul_seq.
//   in_valid/in_ready/in_data    : A then B elements, row-major, into the block
//   out_valid/out_ready/out_data : C elements, row-major, out of the block
// master : producer/consumer side (drives inputs, accepts results)
// slave  : the matrix multiplier
interface fp_matmul_seq_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp_matmul_seq.sv
// Sequential fixed-point matrix multiplier, C = A x B, one signed MAC per cycle.
// A (ROW_1 x COL_1) then B (COL_1 x COL_2) stream in row-major over the bus,
// C streams out row-major, each element sat(acc >>> FRAC_BITS).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begins a job, honoured only while idle
//   bus        : input/output valid-ready streams (slave modport)
//   busy       : high whenever a job is in progress
//   done       : one-cycle pulse after the last C element handshakes
module fp_matmul_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ROW_1      = 4,
    parameter int COL_1      = 4,
    parameter int COL_2      = 4,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    fp_matmul_seq_if.slave        bus,
    output logic                  busy,
    output logic                  done
);
    localparam int NA = ROW_1 * COL_1;
    localparam int NB = COL_1 * COL_2;
    localparam int AW = (NA > 1) ? $clog2(NA) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int WW = (AW > BW) ? AW : BW;
    localparam int IW = (ROW_1 > 1) ? $clog2(ROW_1) : 1;
    localparam int JW = (COL_2 > 1) ? $clog2(COL_2) : 1;
    localparam int KW = (COL_1 > 1) ? $clog2(COL_1) : 1;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUT} state_t;

    state_t                        state_q;
    logic [WW-1:0]                 wr_idx_q;
    logic [IW-1:0]                 i_q;
    logic [JW-1:0]                 j_q;
    logic [KW-1:0]                 k_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic [DATA_WIDTH-1:0]         out_data_q;
    logic                          busy_q;
    logic                          done_q;

    logic signed [DATA_WIDTH-1:0]  a_q [NA];
    logic signed [DATA_WIDTH-1:0]  b_q [NB];

    logic                          wr_en;
    logic [AW-1:0]                 a_idx;
    logic [BW-1:0]                 b_idx;
    logic signed [DATA_WIDTH-1:0]  a_rd;
    logic signed [DATA_WIDTH-1:0]  b_rd;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0]   acc_shr;
    logic [DATA_WIDTH-1:0]         sat_val;

    assign wr_en         = bus.in_valid & in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_comb begin
        a_idx   = AW'(int'(i_q) * COL_1 + int'(k_q));
        b_idx   = BW'(int'(k_q) * COL_2 + int'(j_q));
        a_rd    = a_q[a_idx];
        b_rd    = b_q[b_idx];
        prod    = PW'(a_rd) * PW'(b_rd);
        acc_sum = ((k_q == '0) ? '0 : acc_q) + ACC_WIDTH'(prod);
        acc_shr = acc_q >>> FRAC_BITS;
        if (acc_shr > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (acc_shr < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_val = acc_shr[DATA_WIDTH-1:0];
        end
    end

    // Operand buffers carry no reset; every job rewrites them fully before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (state_q == LOAD_A) begin
                a_q[AW'(wr_idx_q)] <= bus.in_data;
            end else begin
                b_q[BW'(wr_idx_q)] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_idx_q    <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD_A;
                        wr_idx_q   <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD_A: begin
                    if (wr_en) begin
                        if (wr_idx_q == WW'(NA - 1)) begin
                            wr_idx_q <= '0;
                            state_q  <= LOAD_B;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (wr_en) begin
                        if (wr_idx_q == WW'(NB - 1)) begin
                            wr_idx_q   <= '0;
                            in_ready_q <= 1'b0;
                            i_q        <= '0;
                            j_q        <= '0;
                            k_q        <= '0;
                            state_q    <= COMPUTE;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    acc_q <= acc_sum;
                    if (k_q == KW'(COL_1 - 1)) begin
                        k_q     <= '0;
                        state_q <= OUT;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                OUT: begin
                    // First OUT cycle registers the formatted result; valid
                    // rises from that register, giving K+1 cycles per element.
                    if (!out_valid_q) begin
                        out_data_q  <= sat_val;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (j_q == JW'(COL_2 - 1)) begin
                            j_q <= '0;
                            if (i_q == IW'(ROW_1 - 1)) begin
                                i_q     <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                i_q     <= i_q + 1'b1;
                                state_q <= COMPUTE;
                            end
                        end else begin
                            j_q     <= j_q + 1'b1;
                            state_q <= COMPUTE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
